// File: rtl/l2_thr_ctrl.sv
// l2_thr_ctrl: threshold-adaptation controller for the 10-neuron L2 layer.
// Ports: i_clk/i_rst (sync, active-high); i_enable, i_label, i_spike, i_sv in;
//        i_wr_en/i_wr_addr/i_wr_data host write; o_threshold packed thresholds;
//        o_busy/o_reward/o_punish status; o_winner last rewarded neuron.
// Optional macro THR_LEAK_EN: periodic +1 leak of thresholds below P_THR_INIT.
module l2_thr_ctrl #(
  parameter int P_N           = 10,
  parameter int P_THR_WIDTH   = 20,
  parameter int P_ETA         = 4,
  parameter int P_DEC         = 8,
  parameter int P_THR_MIN     = 16,
  parameter int P_THR_INIT    = 1024,
  parameter int P_WIN         = 16,
  parameter int P_LEAK_PERIOD = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_label,
  input  logic [P_N:1]               i_spike,
  input  logic [P_N*P_THR_WIDTH-1:0] i_sv,
  input  logic                       i_wr_en,
  input  logic [3:0]                 i_wr_addr,
  input  logic [P_THR_WIDTH-1:0]     i_wr_data,
  output logic [P_N*P_THR_WIDTH-1:0] o_threshold,
  output logic                       o_busy,
  output logic                       o_reward,
  output logic                       o_punish,
  output logic [3:0]                 o_winner
);

  localparam int W  = P_THR_WIDTH;
  localparam int CW = $clog2(P_WIN);

  localparam logic [W-1:0]  THR_MIN  = W'(P_THR_MIN);
  localparam logic [W-1:0]  THR_INIT = W'(P_THR_INIT);
  localparam logic [W-1:0]  DEC_V    = W'(P_DEC);
  localparam logic [CW-1:0] WIN_LAST = CW'(P_WIN - 1);
  localparam logic [3:0]    N_IDX    = 4'(P_N);

  typedef enum logic [1:0] {IDLE, WAIT, REWARD, PUNISH} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    pidx;
  logic [3:0]    win_idx;
  logic [W-1:0]  win_sv;
  logic [W-1:0]  thr [1:P_N];

  logic          latch_win, cnt_clr, cnt_inc;
  logic          spike_any;
  logic [3:0]    spk_idx;
  logic [W-1:0]  spk_sv;
  logic          wr_ok;

  assign spike_any = |i_spike;
  assign wr_ok     = (state == IDLE) && i_wr_en && (i_wr_addr != 4'd0) && (i_wr_addr <= N_IDX);

  // Lowest set bit wins: scan from the top so the lowest index is written last.
  always_comb begin
    spk_idx = 4'd0;
    spk_sv  = '0;
    for (int i = P_N; i >= 1; i--) begin
      if (i_spike[i]) begin
        spk_idx = 4'(i);
        spk_sv  = i_sv[(i-1)*W +: W];
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    nxt       = state;
    latch_win = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (i_label && i_enable) begin
          if (spike_any) begin
            latch_win = 1'b1;
            nxt       = REWARD;
          end else begin
            cnt_clr = 1'b1;
            nxt     = WAIT;
          end
        end
      end
      WAIT: begin
        if (!i_enable) begin
          nxt = IDLE;
        end else if (spike_any) begin
          latch_win = 1'b1;
          nxt       = REWARD;
        end else if (i_label) begin
          cnt_clr = 1'b1;
        end else if (cnt == WIN_LAST) begin
          nxt = PUNISH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      REWARD: nxt = IDLE;
      PUNISH: if (pidx == N_IDX) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pidx     <= 4'd0;
      win_idx  <= 4'd0;
      win_sv   <= '0;
      o_winner <= 4'd0;
    end else begin
      state <= nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (latch_win) begin
        win_idx <= spk_idx;
        win_sv  <= spk_sv;
      end
      if (state == WAIT && nxt == PUNISH) pidx <= 4'd1;
      else if (state == PUNISH)           pidx <= pidx + 4'd1;
      if (state == REWARD) o_winner <= win_idx;
    end
  end

  assign o_busy   = (state != IDLE);
  assign o_reward = (state == REWARD);
  assign o_punish = (state == PUNISH);

  // Reward: thr + floor((sv - thr) / 2^ETA), clamped to [THR_MIN, 2^W-1].
  logic [W-1:0]      rew_thr, rew_val, pun_thr, pun_val, wr_val;
  logic signed [W:0]   diff, step;
  logic signed [W+1:0] sum;

  always_comb begin
    rew_thr = thr[win_idx];
    diff    = $signed({1'b0, win_sv}) - $signed({1'b0, rew_thr});
    step    = diff >>> P_ETA;
    sum     = $signed({step[W], step}) + $signed({2'b00, rew_thr});
    if (sum < $signed({2'b00, THR_MIN}))
      rew_val = THR_MIN;
    else if (sum > $signed({2'b00, {W{1'b1}}}))
      rew_val = {W{1'b1}};
    else
      rew_val = sum[W-1:0];

    pun_thr = thr[pidx];
    // Compare before subtracting so the floor also guards against wrap-around.
    if ({1'b0, pun_thr} >= ({1'b0, THR_MIN} + {1'b0, DEC_V}))
      pun_val = pun_thr - DEC_V;
    else
      pun_val = THR_MIN;

    wr_val = (i_wr_data < THR_MIN) ? THR_MIN : i_wr_data;
  end

`ifdef THR_LEAK_EN
  localparam int LW = (P_LEAK_PERIOD > 1) ? $clog2(P_LEAK_PERIOD) : 1;
  localparam logic [LW-1:0] LEAK_LAST = LW'(P_LEAK_PERIOD - 1);
  logic [LW-1:0] leak_cnt;
  logic          leak_wrap;

  assign leak_wrap = (leak_cnt == LEAK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst)          leak_cnt <= '0;
    else if (leak_wrap) leak_cnt <= '0;
    else                leak_cnt <= leak_cnt + 1'b1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 1; i <= P_N; i++) thr[i] <= THR_INIT;
    end else begin
      case (state)
        REWARD: thr[win_idx] <= rew_val;
        PUNISH: thr[pidx]    <= pun_val;
        IDLE: begin
          if (wr_ok) begin
            thr[i_wr_addr] <= wr_val;
          end
`ifdef THR_LEAK_EN
          // A wrap that coincides with a write (or a busy state) skips this period.
          else if (leak_wrap) begin
            for (int i = 1; i <= P_N; i++)
              if (thr[i] < THR_INIT) thr[i] <= thr[i] + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 1; g <= P_N; g++) begin : g_pack
    assign o_threshold[(g-1)*W +: W] = thr[g];
  end

endmodule

// File: tb/tb_l2_thr_ctrl.sv
// tb_l2_thr_ctrl: directed-vector bench for l2_thr_ctrl.
// Inputs are driven on the falling edge, outputs checked on the next falling edge.
// Expected values are hand-computed constants from the behavioural description.
module tb_l2_thr_ctrl;

  localparam int N = 10;
  localparam int W = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           label;
  logic [N:1]     spike;
  logic [N*W-1:0] sv;
  logic           wr_en;
  logic [3:0]     wr_addr;
  logic [W-1:0]   wr_data;
  logic [N*W-1:0] threshold;
  logic           busy, reward, punish;
  logic [3:0]     winner;

  int tests_run = 0;
  int tests_failed = 0;

  l2_thr_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_label(label),
    .i_spike(spike), .i_sv(sv), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_threshold(threshold), .o_busy(busy),
    .o_reward(reward), .o_punish(punish), .o_winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int thr_of(input int i);
    return int'(threshold[(i-1)*W +: W]);
  endfunction

  task automatic set_sv(input int i, input int val);
    sv[(i-1)*W +: W] = W'(val);
  endtask

  task automatic write_thr(input int addr, input int data);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = W'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_label();
    label = 1'b1;
    tick();
    label = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; enable = 1'b1; label = 1'b0; spike = '0; sv = '0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    for (int i = 1; i <= N; i++) check_eq($sformatf("reset_thr%0d", i), thr_of(i), 1024);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_winner", int'(winner), 0);
    check_eq("reset_reward", int'(reward), 0);
    check_eq("reset_punish", int'(punish), 0);

    // Reward after a delayed spike: 1000 + floor(1000/16) = 1062
    write_thr(3, 1000);
    check_eq("wr_thr3", thr_of(3), 1000);
    set_sv(3, 2000);
    pulse_label();
    check_eq("a_wait_busy", int'(busy), 1);
    tick();
    spike = 10'b0000000100;
    tick();
    spike = '0;
    check_eq("a_reward_pulse", int'(reward), 1);
    tick();
    check_eq("a_reward_done", int'(reward), 0);
    check_eq("a_busy_done", int'(busy), 0);
    check_eq("a_thr3", thr_of(3), 1062);
    check_eq("a_winner", int'(winner), 3);
    check_eq("a_thr1", thr_of(1), 1024);
    check_eq("a_thr4", thr_of(4), 1024);

    // Immediate reward, negative step: 1000 + floor(-800/16) = 950
    write_thr(5, 1000);
    set_sv(5, 200);
    label = 1'b1; spike = 10'b0000010000;
    tick();
    label = 1'b0; spike = '0;
    check_eq("b_busy1", int'(busy), 1);
    tick();
    check_eq("b_busy0", int'(busy), 0);
    check_eq("b_thr5", thr_of(5), 950);
    check_eq("b_winner", int'(winner), 5);

    // Timeout punish: 16 WAIT cycles, 10 PUNISH cycles
    write_thr(3, 1024);
    write_thr(5, 1024);
    write_thr(7, 20);
    pulse_label();
    n = 0;
    while (busy && !punish && n < 40) begin n++; tick(); end
    check_eq("c_wait_len", n, 16);
    n = 0;
    while (punish && n < 20) begin n++; tick(); end
    check_eq("c_punish_len", n, 10);
    check_eq("c_idle", int'(busy), 0);
    for (int i = 1; i <= N; i++)
      check_eq($sformatf("c_thr%0d", i), thr_of(i), (i == 7) ? 16 : 1016);

    // Multiple spikes: lowest index wins. 1016 + floor(984/16) = 1077
    set_sv(2, 2000);
    set_sv(3, 3000);
    pulse_label();
    spike = 10'b0000000110;
    tick();
    spike = '0;
    tick();
    check_eq("d_thr2", thr_of(2), 1077);
    check_eq("d_thr3", thr_of(3), 1016);
    check_eq("d_winner", int'(winner), 2);

    // Enable drop in WAIT returns to IDLE with no update
    pulse_label();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_eq("d_abort_busy", int'(busy), 0);
    check_eq("d_abort_thr1", thr_of(1), 1016);

    // Relabel at count 10 restarts the window
    pulse_label();
    for (int i = 0; i < 10; i++) tick();
    pulse_label();
    n = 0;
    while (busy && !punish && n < 40) begin n++; tick(); end
    check_eq("d_relabel_wait", n, 16);
    n = 0;
    while (punish && n < 20) begin n++; tick(); end
    check_eq("d_punish_len", n, 10);
    check_eq("d_thr2_pun", thr_of(2), 1069);
    check_eq("d_thr7_pun", thr_of(7), 16);

    // Host writes
    pulse_label();
    write_thr(4, 500);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_eq("e_busy_wr", thr_of(4), 1008);
    write_thr(4, 500);
    check_eq("e_wr_500", thr_of(4), 500);
    write_thr(4, 5);
    check_eq("e_wr_floor", thr_of(4), 16);
    write_thr(11, 700);
    check_eq("e_wr_addr11_thr4", thr_of(4), 16);
    check_eq("e_wr_addr11_thr10", thr_of(10), 1008);
    write_thr(0, 700);
    check_eq("e_wr_addr0_thr1", thr_of(1), 1008);

    // Write and label in the same cycle are both honoured
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = W'(800); label = 1'b1;
    tick();
    wr_en = 1'b0; label = 1'b0;
    check_eq("e_wr_lbl_busy", int'(busy), 1);
    check_eq("e_wr_lbl_thr4", thr_of(4), 800);
    enable = 1'b0;
    tick();
    enable = 1'b1;

    // Idle drift: leak raises by one per period, otherwise nothing changes
    write_thr(4, 500);
    for (int i = 0; i < 256; i++) tick();
`ifdef THR_LEAK_EN
    check_eq("f_leak_thr4", thr_of(4), 501);
`else
    check_eq("f_noleak_thr4", thr_of(4), 500);
`endif

    // Synchronous reset mid-WAIT
    pulse_label();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("g_rst_busy", int'(busy), 0);
    check_eq("g_rst_thr4", thr_of(4), 1024);
    check_eq("g_rst_winner", int'(winner), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
